viterbi_decoder: RTL and testbench

//  Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (G1=111, G2=101)

---
 rtl/codec_pkg.sv | 20 ++
 rtl/viterbi_acs.sv | 21 ++
 rtl/viterbi_decoder.sv | 79 +++++++
 tb/tb_viterbi_decoder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// codec_pkg: constants and helpers for the K=3, rate-1/2 (G1=111, G2=101) convolutional codec.
package codec_pkg;
    localparam int K = 3;
    localparam int NUM_STATES = 4;
    localparam logic [K-1:0] G1 = 3'b111;
    localparam logic [K-1:0] G2 = 3'b101;

    // state = {s1, s0}; taps are {u, s1, s0}
    function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic u);
        logic [K-1:0] taps;
        taps = {u, state};
        return {^(taps & G1), ^(taps & G2)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction
endpackage

// File: rtl/viterbi_acs.sv
// viterbi_acs: saturating add-compare-select for one trellis state; ties favour candidate 0.
module viterbi_acs #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] cand,
    output logic            dec
);
    logic [PM_W:0]   sum0, sum1;
    logic [PM_W-1:0] c0, c1;

    assign sum0 = {1'b0, pm0} + (PM_W+1)'(bm0);
    assign sum1 = {1'b0, pm1} + (PM_W+1)'(bm1);
    assign c0   = sum0[PM_W] ? '1 : sum0[PM_W-1:0];
    assign c1   = sum1[PM_W] ? '1 : sum1[PM_W-1:0];
    assign dec  = c1 < c0;
    assign cand = dec ? c1 : c0;
endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision Viterbi decoder for the K=3 (111,101) code with
// register-exchange survivors; one decoded bit per accepted symbol after TB_DEPTH symbols.
module viterbi_decoder
    import codec_pkg::*;
#(
    parameter int TB_DEPTH = 15,
    parameter int PM_W     = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [1:0]      in,
    output logic            out_valid,
    output logic            out,
    output logic [PM_W-1:0] best_metric
);
    localparam int CW = $clog2(TB_DEPTH + 1);

    logic [PM_W-1:0]     pm       [NUM_STATES];
    logic [PM_W-1:0]     cand     [NUM_STATES];
    logic [PM_W-1:0]     pm_new   [NUM_STATES];
    logic [TB_DEPTH-1:0] surv     [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_new [NUM_STATES];
    logic [NUM_STATES-1:0] dec;
    logic [PM_W-1:0]     min_pm;
    logic [1:0]          best;
    logic [CW-1:0]       cnt;

    // next state n = {u, a} is reached from {a, 0} and {a, 1}
    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam int U  = n / 2;
        localparam int P0 = (n % 2) * 2;
        localparam int P1 = P0 + 1;
        viterbi_acs #(.PM_W(PM_W)) u_acs (
            .pm0  (pm[P0]),
            .pm1  (pm[P1]),
            .bm0  (hamming2(in, exp_sym(2'(P0), 1'(U)))),
            .bm1  (hamming2(in, exp_sym(2'(P1), 1'(U)))),
            .cand (cand[n]),
            .dec  (dec[n])
        );
        assign surv_new[n] = {dec[n] ? surv[P1][TB_DEPTH-2:0] : surv[P0][TB_DEPTH-2:0], 1'(U)};
        assign pm_new[n]   = cand[n] - min_pm;
    end

    // the lowest candidate is also the lowest normalised metric
    always_comb begin
        min_pm = cand[0];
        best   = '0;
        for (int i = 1; i < NUM_STATES; i++) begin
            best   = (cand[i] < min_pm) ? 2'(i) : best;
            min_pm = (cand[i] < min_pm) ? cand[i] : min_pm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm[i]   <= (i == 0) ? '0 : '1;
                surv[i] <= '0;
            end
            cnt         <= '0;
            out_valid   <= 1'b0;
            out         <= 1'b0;
            best_metric <= '0;
        end else begin
            out_valid <= in_valid && (cnt >= CW'(TB_DEPTH - 1));
            if (in_valid) begin
                for (int i = 0; i < NUM_STATES; i++) begin
                    pm[i]   <= pm_new[i];
                    surv[i] <= surv_new[i];
                end
                cnt         <= (cnt == CW'(TB_DEPTH)) ? cnt : cnt + 1'b1;
                out         <= surv_new[best][TB_DEPTH-1];
                best_metric <= pm_new[best];
            end
        end
    end
endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: directed and random checks of viterbi_decoder at TB_DEPTH 5 and 15,
// with a reference encoder feeding a queue of expected decoded bits.
module tb_viterbi_decoder;
    logic       clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [1:0] iv  = 2'b00;
    logic [1:0] sym0 = 2'b00, sym1 = 2'b00;
    logic       ov0, ov1, o0, o1;
    logic [5:0] bm0, bm1;

    int   checks = 0;
    int   errors = 0;
    int   sel = 0;
    int   depth = 5;
    int   acc = 0;
    bit [1:0] es = 2'b00;
    bit   pend_v = 1'b0;
    bit   last_out = 1'b0;
    bit   dq[$];
    bit   exp_q[$];
    bit   t1[8] = '{1, 1, 1, 0, 1, 0, 0, 0};

    always #5 clk = ~clk;

    viterbi_decoder #(.TB_DEPTH(5), .PM_W(6)) dut5 (
        .clk(clk), .reset(rst[0]), .in_valid(iv[0]), .in(sym0),
        .out_valid(ov0), .out(o0), .best_metric(bm0)
    );

    viterbi_decoder #(.TB_DEPTH(15), .PM_W(6)) dut15 (
        .clk(clk), .reset(rst[1]), .in_valid(iv[1]), .in(sym1),
        .out_valid(ov1), .out(o1), .best_metric(bm1)
    );

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (sym %0d, depth %0d)", tag, obs, exp, acc, depth);
        end
    endtask

    task automatic sample();
        logic dov, dout;
        logic [5:0] dbm;
        bit e;
        dov  = sel ? ov1 : ov0;
        dout = sel ? o1 : o0;
        dbm  = sel ? bm1 : bm0;
        chk("out_valid", 6'(dov), 6'(pend_v));
        chk("best_metric", dbm, 6'd0);
        if (pend_v) begin
            e = exp_q.pop_front();
            chk("out", 6'(dout), 6'(e));
            last_out = e;
        end else begin
            chk("out_hold", 6'(dout), 6'(last_out));
        end
    endtask

    task automatic cycle(input bit v, input logic [1:0] s, input bit u);
        @(negedge clk);
        sample();
        iv[sel] = v;
        if (sel == 1) sym1 = s; else sym0 = s;
        pend_v = 1'b0;
        if (v) begin
            dq.push_back(u);
            acc++;
            if (acc >= depth) begin
                exp_q.push_back(dq[acc - depth]);
                pend_v = 1'b1;
            end
        end
    endtask

    task automatic send(input bit u, input bit [1:0] flip, input int gap);
        logic [1:0] s;
        s  = {u ^ es[1] ^ es[0], u ^ es[0]} ^ flip;
        es = {u, es[1]};
        cycle(1'b1, s, u);
        repeat (gap) cycle(1'b0, 2'($urandom), 1'b0);
    endtask

    // reset is held together with a valid symbol to show reset wins
    task automatic do_reset();
        @(negedge clk);
        sample();
        rst[sel] = 1'b1;
        iv[sel]  = 1'b1;
        if (sel == 1) sym1 = 2'b11; else sym0 = 2'b11;
        @(negedge clk);
        chk("rst_out_valid", 6'(sel ? ov1 : ov0), 6'd0);
        chk("rst_out", 6'(sel ? o1 : o0), 6'd0);
        chk("rst_best_metric", sel ? bm1 : bm0, 6'd0);
        rst[sel] = 1'b0;
        iv[sel]  = 1'b0;
        es = 2'b00; acc = 0; pend_v = 1'b0; last_out = 1'b0;
        dq.delete();
        exp_q.delete();
    endtask

    task automatic run_t1(input bit flip3, input bit gaps);
        for (int i = 0; i < 15; i++)
            send(i < 8 ? t1[i] : 1'b0, (flip3 && i == 2) ? 2'b10 : 2'b00,
                 gaps ? int'($urandom_range(1, 3)) : 0);
    endtask

    initial begin
        sel = 0; depth = 5;
        do_reset();
        run_t1(1'b0, 1'b0);
        do_reset();
        run_t1(1'b1, 1'b0);
        do_reset();
        repeat (40) send(1'b0, 2'b00, 0);
        do_reset();
        run_t1(1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) send(t1[i], 2'b00, 0);
        do_reset();
        run_t1(1'b0, 1'b0);
        cycle(1'b0, 2'b00, 1'b0);
        sel = 1; depth = 15;
        do_reset();
        for (int i = 0; i < 1014; i++)
            send(i < 1000 ? 1'($urandom) : 1'b0,
                 (i % 20 == 7) ? ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b01) : 2'b00, 0);
        cycle(1'b0, 2'b00, 1'b0);
        cycle(1'b0, 2'b00, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
